// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types and address-split helpers for the
// set-associative data cache controller.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    ALLOCATE,
    RETRY
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  function automatic int off_w(input int line_bits);
    return clog2(line_bits / 8);
  endfunction

  function automatic int idx_w(input int sets);
    return clog2(sets);
  endfunction

  function automatic int tag_w(input int addr_w,
                               input int sets,
                               input int line_bits);
    return addr_w - idx_w(sets) - off_w(line_bits);
  endfunction

  // A 1-way cache still carries a 1-bit (always zero) age.
  function automatic int age_w(input int ways);
    return (ways > 1) ? clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/dcache_assoc_ctrl_lru.sv
// dcache_lru: true-LRU age vector for one set (0 = MRU).
// Ports: upd_i/fill_i/way_i select the update, victim_o = oldest way.
module dcache_lru
  import dcache_pkg::*;
#(
  parameter int WAYS = 2,
  parameter int AW   = 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          upd_i,
  input  logic          fill_i,
  input  logic [AW-1:0] way_i,
  output logic [AW-1:0] victim_o
);

  logic [WAYS-1:0][AW-1:0] age_q, age_d;
  logic [AW-1:0]           old;

  // A refill is ranked as if it came from the oldest slot, so
  // the all-zero reset ages become a permutation as ways fill.
  always_comb begin
    old   = fill_i ? AW'(WAYS - 1) : age_q[way_i];
    age_d = age_q;
    for (int w = 0; w < WAYS; w++) begin
      if (AW'(w) == way_i)
        age_d[w] = '0;
      else if (age_q[w] < old)
        age_d[w] = age_q[w] + 1'b1;
    end
  end

  always_comb begin
    victim_o = '0;
    for (int w = 0; w < WAYS; w++)
      if (age_q[w] == AW'(WAYS - 1))
        victim_o = AW'(w);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)
      age_q <= '0;
    else if (upd_i)
      age_q <= age_d;
  end

endmodule

// File: rtl/dcache_assoc_ctrl.sv
// dcache_assoc_ctrl: N-way write-back/write-allocate dcache with
// true-LRU. p1_* = CPU side, mem_* = 256-bit memory, *_cnt_o = perf.
module dcache_assoc_ctrl
  import dcache_pkg::*;
#(
  parameter int WAYS      = 2,
  parameter int SETS      = 32,
  parameter int LINE_BITS = 256,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [DATA_W-1:0]    p1_data_i,
  input  logic [ADDR_W-1:0]    p1_addr_i,
  input  logic                 p1_MemRead_i,
  input  logic                 p1_MemWrite_i,
  output logic [DATA_W-1:0]    p1_data_o,
  output logic                 p1_stall_o,
  input  logic [LINE_BITS-1:0] mem_data_i,
  input  logic                 mem_ack_i,
  output logic [LINE_BITS-1:0] mem_data_o,
  output logic [ADDR_W-1:0]    mem_addr_o,
  output logic                 mem_enable_o,
  output logic                 mem_write_o,
  output logic [31:0]          hit_cnt_o,
  output logic [31:0]          miss_cnt_o
);

  localparam int OFF = off_w(LINE_BITS);
  localparam int IDX = idx_w(SETS);
  localparam int TAG = tag_w(ADDR_W, SETS, LINE_BITS);
  localparam int AW  = age_w(WAYS);
  localparam int BO  = clog2(DATA_W / 8);
  localparam int WS  = OFF - BO;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] req_addr_q;
  logic [DATA_W-1:0] req_data_q;
  logic              req_wr_q;
  logic              replay_q;
  logic [AW-1:0]     vic_q;
  logic [31:0]       hit_cnt_q, miss_cnt_q;

  logic [SETS-1:0][WAYS-1:0] valid_q, dirty_q;
  logic [TAG-1:0]       tag_q  [SETS][WAYS];
  logic [LINE_BITS-1:0] line_q [SETS][WAYS];

  // The cycle after RETRY replays the latched request.
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_data;
  logic              cur_wr, cur_req;

  assign cur_addr = replay_q ? req_addr_q : p1_addr_i;
  assign cur_data = replay_q ? req_data_q : p1_data_i;
  assign cur_wr   = replay_q ? req_wr_q : p1_MemWrite_i;
  assign cur_req  = replay_q | p1_MemRead_i | p1_MemWrite_i;

  logic [IDX-1:0] idx, r_idx;
  logic [TAG-1:0] tag, r_tag;
  logic [WS-1:0]  wsel;
  logic           unused_bits;

  assign idx   = cur_addr[OFF +: IDX];
  assign tag   = cur_addr[ADDR_W-1 -: TAG];
  assign wsel  = cur_addr[BO +: WS];
  assign r_idx = req_addr_q[OFF +: IDX];
  assign r_tag = req_addr_q[ADDR_W-1 -: TAG];
  assign unused_bits = ^cur_addr[BO-1:0];

  logic          hit, inv_found;
  logic [AW-1:0] hit_way, inv_way, vic_way;

  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = 0; w < WAYS; w++)
      if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
        hit     = 1'b1;
        hit_way = AW'(w);
      end
    for (int w = WAYS - 1; w >= 0; w--)
      if (!valid_q[idx][w]) begin
        inv_found = 1'b1;
        inv_way   = AW'(w);
      end
  end

  logic [SETS-1:0][AW-1:0] lru_vic;
  logic [SETS-1:0]         lru_upd;
  logic                    lru_fill;
  logic [AW-1:0]           lru_way;
  logic                    idle_hit, alloc_ack;

  assign vic_way   = inv_found ? inv_way : lru_vic[idx];
  assign idle_hit  = (state_q == IDLE) && cur_req && hit;
  assign alloc_ack = (state_q == ALLOCATE) && mem_ack_i;

  always_comb begin
    lru_upd  = '0;
    lru_fill = 1'b0;
    lru_way  = hit_way;
    if (alloc_ack) begin
      lru_upd[r_idx] = 1'b1;
      lru_fill       = 1'b1;
      lru_way        = vic_q;
    end else if (idle_hit) begin
      lru_upd[idx] = 1'b1;
    end
  end

  for (genvar s = 0; s < SETS; s++) begin : g_lru
    dcache_lru #(
      .WAYS(WAYS),
      .AW  (AW)
    ) u_lru (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .upd_i   (lru_upd[s]),
      .fill_i  (lru_fill),
      .way_i   (lru_way),
      .victim_o(lru_vic[s])
    );
  end

  logic stall;

  always_comb begin
    state_d      = state_q;
    stall        = 1'b0;
    p1_data_o    = '0;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    unique case (state_q)
      IDLE: begin
        if (cur_req) begin
          if (hit) begin
            p1_data_o =
              line_q[idx][hit_way][int'(wsel)*DATA_W +: DATA_W];
          end else begin
            stall = 1'b1;
            if (valid_q[idx][vic_way] && dirty_q[idx][vic_way])
              state_d = WRITEBACK;
            else
              state_d = ALLOCATE;
          end
        end
      end
      WRITEBACK: begin
        stall        = 1'b1;
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {tag_q[r_idx][vic_q], r_idx, {OFF{1'b0}}};
        mem_data_o   = line_q[r_idx][vic_q];
        if (mem_ack_i) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        stall        = 1'b1;
        mem_enable_o = 1'b1;
        mem_addr_o   = {r_tag, r_idx, {OFF{1'b0}}};
        if (mem_ack_i) state_d = RETRY;
      end
      RETRY: begin
        stall   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset must silence the stall even with a request pending.
  assign p1_stall_o = rst_i & stall;
  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      req_addr_q <= '0;
      req_data_q <= '0;
      req_wr_q   <= 1'b0;
      replay_q   <= 1'b0;
      vic_q      <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      valid_q    <= '0;
      dirty_q    <= '0;
    end else begin
      state_q  <= state_d;
      replay_q <= (state_q == RETRY);
      if (state_q == IDLE && cur_req) begin
        if (hit) begin
          if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 1;
          if (cur_wr) dirty_q[idx][hit_way] <= 1'b1;
        end else begin
          if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 1;
          req_addr_q <= cur_addr;
          req_data_q <= cur_data;
          req_wr_q   <= cur_wr;
          vic_q      <= vic_way;
        end
      end
      if (alloc_ack) begin
        valid_q[r_idx][vic_q] <= 1'b1;
        dirty_q[r_idx][vic_q] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (idle_hit && cur_wr)
      line_q[idx][hit_way][int'(wsel)*DATA_W +: DATA_W] <= cur_data;
    if (alloc_ack) begin
      line_q[r_idx][vic_q] <= mem_data_i;
      tag_q[r_idx][vic_q]  <= r_tag;
    end
  end

endmodule
